// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT0 = 2'd1,
      ST_WAIT1 = 2'd2
   } arb_state_e;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the cpu (m0) and the debug/loader port (m1) on a
// single-port memory; one access at a time, reads tracked until data or timeout.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_ren,
   input  logic          m0_wen,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [3:0]    m0_wmask,
   output logic          m0_gnt,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_rd_valid,
   input  logic          m1_ren,
   input  logic          m1_wen,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic [3:0]    m1_wmask,
   output logic          m1_gnt,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_rd_valid,
   output logic          mem_ren,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_wmask,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rd_valid,
   output logic          timeout,
   output logic          proto_err
);

   arb_state_e    state;
   logic          last;
   logic [7:0]    timer;
   logic [AW-1:0] raddr;

   logic          req0;
   logic          req1;
   logic          sel1;
   logic          w_ren;
   logic          w_wen;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic [3:0]    w_wmask;
   logic          expire;
   logic          rd_done;
   logic [DW-1:0] rd_data;

   // Request mux: pick the winner and select its fields.
   always_comb begin
      req0    = m0_ren | m0_wen;
      req1    = m1_ren | m1_wen;
      // m1 wins when alone, or on a tie when m0 was served last
      sel1    = req1 & (~req0 | ~last);
      w_ren   = sel1 ? m1_ren   : m0_ren;
      w_wen   = sel1 ? m1_wen   : m0_wen;
      w_addr  = sel1 ? m1_addr  : m0_addr;
      w_wdata = sel1 ? m1_wdata : m0_wdata;
      w_wmask = sel1 ? m1_wmask : m0_wmask;
      expire  = (timer == 8'(TIMEOUT - 1));
      rd_done = mem_rd_valid | expire;
      rd_data = mem_rd_valid ? mem_rdata : DW'(TIMEOUT_DATA);
   end

   // Bus outputs: combinational grant in IDLE, read return routing in WAITn.
   always_comb begin
      m0_gnt      = 1'b0;
      m1_gnt      = 1'b0;
      m0_rd_valid = 1'b0;
      m1_rd_valid = 1'b0;
      m0_rdata    = {DW{1'b0}};
      m1_rdata    = {DW{1'b0}};
      mem_ren     = 1'b0;
      mem_wen     = 1'b0;
      mem_addr    = {AW{1'b0}};
      mem_wdata   = {DW{1'b0}};
      mem_wmask   = 4'b1111;
      timeout     = 1'b0;
      if (!rst_n) begin
         timeout = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req0 | req1) begin
                  m0_gnt    = ~sel1;
                  m1_gnt    = sel1;
                  mem_wen   = w_wen;
                  mem_ren   = ~w_wen;
                  mem_addr  = w_addr;
                  mem_wdata = w_wdata;
                  mem_wmask = w_wmask;
               end else begin
                  mem_wmask = 4'b1111;
               end
            end
            ST_WAIT0, ST_WAIT1: begin
               mem_addr = raddr;
               timeout  = rd_done & ~mem_rd_valid;
               if (rd_done && state == ST_WAIT1) begin
                  m1_rd_valid = 1'b1;
                  m1_rdata    = rd_data;
               end else if (rd_done) begin
                  m0_rd_valid = 1'b1;
                  m0_rdata    = rd_data;
               end else begin
                  timeout = 1'b0;
               end
            end
            default: begin
               mem_wmask = 4'b1111;
            end
         endcase
      end
   end

   // Arbiter FSM: priority tracking, read latch, timeout timer, sticky protocol error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         last      <= 1'b1;
         timer     <= 8'd0;
         raddr     <= {AW{1'b0}};
         proto_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if ((req0 | req1) && w_wen) begin
                  last <= sel1;
                  if (w_ren) begin
                     proto_err <= 1'b1;
                  end else begin
                     proto_err <= proto_err;
                  end
               end else if (req0 | req1) begin
                  timer <= 8'd0;
                  raddr <= w_addr;
                  state <= sel1 ? ST_WAIT1 : ST_WAIT0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT0, ST_WAIT1: begin
               if (rd_done) begin
                  last  <= (state == ST_WAIT1);
                  state <= ST_IDLE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter, built with TIMEOUT=4.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_ren, m0_wen, m1_ren, m1_wen;
   logic [15:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_wmask, m1_wmask;
   logic        m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_ren, mem_wen, mem_rd_valid, timeout, proto_err;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(16), .DW(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wmask(m0_wmask), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rd_valid(m0_rd_valid),
      .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wmask(m1_wmask), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rd_valid(m1_rd_valid),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid),
      .timeout(timeout), .proto_err(proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one clock, then settle so the next inputs/checks sit mid-cycle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst_n = 1'b0;
      m0_ren = 1'b0; m0_wen = 1'b0; m0_addr = 16'h0; m0_wdata = 32'h0; m0_wmask = 4'hF;
      m1_ren = 1'b0; m1_wen = 1'b0; m1_addr = 16'h0; m1_wdata = 32'h0; m1_wmask = 4'hF;
      mem_rd_valid = 1'b0; mem_rdata = 32'h0;
      tick();
      tick();
      // outputs held quiet while in reset, even with a request present
      m0_ren = 1'b1;
      settle();
      chk("rst_gnt0", 32'(m0_gnt), 32'd0);
      chk("rst_mem_ren", 32'(mem_ren), 32'd0);
      chk("rst_proto", 32'(proto_err), 32'd0);
      m0_ren = 1'b0;
      tick();
      rst_n = 1'b1;
      settle();
      chk("idle_wmask", 32'(mem_wmask), 32'hF);
      chk("idle_addr", 32'(mem_addr), 32'h0);

      // 1: m0 read of 0x40, one-cycle memory
      m0_ren = 1'b1; m0_addr = 16'h0040;
      settle();
      chk("t1_gnt0", 32'(m0_gnt), 32'd1);
      chk("t1_mem_ren", 32'(mem_ren), 32'd1);
      chk("t1_mem_addr", 32'(mem_addr), 32'h40);
      tick();
      mem_rd_valid = 1'b1; mem_rdata = 32'h1234_5678;
      settle();
      chk("t1_rd_valid", 32'(m0_rd_valid), 32'd1);
      chk("t1_rdata", m0_rdata, 32'h1234_5678);
      chk("t1_wait_gnt", 32'(m0_gnt), 32'd0);
      chk("t1_m1_rdata", m1_rdata, 32'h0);
      tick();
      m0_ren = 1'b0; mem_rd_valid = 1'b0;
      settle();
      chk("t1_rdata_idle", m0_rdata, 32'h0);
      chk("t1_late_valid", 32'(m0_rd_valid), 32'd0);

      // 2: both write every cycle; m0 was served last, so m1 leads
      m0_wen = 1'b1; m0_addr = 16'h0010; m0_wdata = 32'hA0A0_0000;
      m1_wen = 1'b1; m1_addr = 16'h0020; m1_wdata = 32'hB1B1_0000;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t2_gnt1", 32'(m1_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("t2_gnt0", 32'(m0_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
         chk("t2_mem_wen", 32'(mem_wen), 32'd1);
         chk("t2_addr", 32'(mem_addr), (i % 2 == 0) ? 32'h20 : 32'h10);
         chk("t2_wdata", mem_wdata, (i % 2 == 0) ? 32'hB1B1_0000 : 32'hA0A0_0000);
         tick();
      end
      m0_wen = 1'b0; m1_wen = 1'b0;

      // 3: after reset, m0 read collides with m1 write
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m0_ren = 1'b1; m0_addr = 16'h0044;
      m1_wen = 1'b1; m1_addr = 16'h0024; m1_wdata = 32'h5555_AAAA;
      settle();
      chk("t3_gnt0", 32'(m0_gnt), 32'd1);
      chk("t3_gnt1", 32'(m1_gnt), 32'd0);
      chk("t3_mem_ren", 32'(mem_ren), 32'd1);
      tick();
      settle();
      chk("t3_wait_gnt1", 32'(m1_gnt), 32'd0);
      chk("t3_wait_wen", 32'(mem_wen), 32'd0);
      chk("t3_wait_addr", 32'(mem_addr), 32'h44);
      tick();
      mem_rd_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      settle();
      chk("t3_rd_valid", 32'(m0_rd_valid), 32'd1);
      chk("t3_rdata", m0_rdata, 32'hCAFE_F00D);
      chk("t3_gnt1_rv", 32'(m1_gnt), 32'd0);
      tick();
      m0_ren = 1'b0; mem_rd_valid = 1'b0;
      settle();
      chk("t3_gnt1_after", 32'(m1_gnt), 32'd1);
      chk("t3_addr_after", 32'(mem_addr), 32'h24);
      tick();
      m1_wen = 1'b0;

      // 4: m1 read, memory silent, TIMEOUT=4
      m1_ren = 1'b1; m1_addr = 16'h0030;
      settle();
      chk("t4_gnt1", 32'(m1_gnt), 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t4_no_valid", 32'(m1_rd_valid), 32'd0);
         chk("t4_no_timeout", 32'(timeout), 32'd0);
         tick();
      end
      settle();
      chk("t4_rd_valid", 32'(m1_rd_valid), 32'd1);
      chk("t4_rdata", m1_rdata, 32'hDEAD_BEEF);
      chk("t4_timeout", 32'(timeout), 32'd1);
      tick();
      m1_ren = 1'b0;
      m0_wen = 1'b1; m0_addr = 16'h0050;
      settle();
      chk("t4_timeout_once", 32'(timeout), 32'd0);
      chk("t4_idle_gnt0", 32'(m0_gnt), 32'd1);
      tick();
      m0_wen = 1'b0;

      // 5: reset during WAIT0, late memory valid must be dropped
      m0_ren = 1'b1; m0_addr = 16'h0060;
      settle();
      chk("t5_gnt0", 32'(m0_gnt), 32'd1);
      tick();
      rst_n = 1'b0;
      settle();
      chk("t5_rst_rv", 32'(m0_rd_valid), 32'd0);
      tick();
      rst_n = 1'b1; m0_ren = 1'b0;
      mem_rd_valid = 1'b1; mem_rdata = 32'h7777_7777;
      settle();
      chk("t5_late_rv0", 32'(m0_rd_valid), 32'd0);
      chk("t5_late_rv1", 32'(m1_rd_valid), 32'd0);
      chk("t5_late_rdata", m0_rdata, 32'h0);
      tick();
      mem_rd_valid = 1'b0;
      m0_wen = 1'b1; m0_addr = 16'h0010;
      m1_wen = 1'b1; m1_addr = 16'h0020;
      settle();
      chk("t5_tie_gnt0", 32'(m0_gnt), 32'd1);
      chk("t5_tie_gnt1", 32'(m1_gnt), 32'd0);
      tick();
      m0_wen = 1'b0; m1_wen = 1'b0;

      // 6: m1 raises ren and wen together
      m1_ren = 1'b1; m1_wen = 1'b1; m1_addr = 16'h0008; m1_wmask = 4'b0011;
      settle();
      chk("t6_pre_proto", 32'(proto_err), 32'd0);
      chk("t6_gnt1", 32'(m1_gnt), 32'd1);
      chk("t6_mem_wen", 32'(mem_wen), 32'd1);
      chk("t6_mem_ren", 32'(mem_ren), 32'd0);
      chk("t6_wmask", 32'(mem_wmask), 32'h3);
      tick();
      m1_wen = 1'b0;
      settle();
      chk("t6_proto", 32'(proto_err), 32'd1);
      chk("t6_pending_ren", 32'(mem_ren), 32'd1);
      tick();
      mem_rd_valid = 1'b1; mem_rdata = 32'h0000_00AB;
      settle();
      chk("t6_rd_valid", 32'(m1_rd_valid), 32'd1);
      tick();
      m1_ren = 1'b0; mem_rd_valid = 1'b0;
      settle();
      chk("t6_sticky", 32'(proto_err), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      settle();
      chk("t6_cleared", 32'(proto_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
